// File: rtl/xadc_drp_sequencer.sv
// Owns the XADC DRP port: reads each enabled channel's result on end-of-conversion
// and slots host configuration writes in between reads, one DRP transaction at a time.
module xadc_drp_sequencer #(
  parameter logic [31:0] CH_MASK        = 32'h0040_0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        eoc_i,
  input  logic [4:0]  channel_i,
  input  logic        cfg_req_i,
  input  logic [6:0]  cfg_addr_i,
  input  logic [15:0] cfg_data_i,
  output logic        cfg_ack_o,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  output logic [6:0]  drp_daddr_o,
  output logic [15:0] drp_di_o,
  input  logic        drp_drdy_i,
  input  logic [15:0] drp_do_i,
  output logic        sample_valid_o,
  output logic [4:0]  sample_chan_o,
  output logic [11:0] sample_data_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        timeout_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t          state;
  logic            pending;
  logic [4:0]      pend_chan;
  logic [CW-1:0]   cnt;

  logic            eoc_hit, rd_go, wr_go, cnt_last;
  logic [4:0]      rd_chan;

  // A fresh eoc seen in IDLE is issued straight away so den follows eoc by one cycle;
  // an older pending request always goes first.
  assign eoc_hit  = eoc_i & CH_MASK[channel_i];
  assign rd_go    = (state == IDLE) && (pending || eoc_hit);
  assign rd_chan  = pending ? pend_chan : channel_i;
  // The ack cycle is excluded so a host that drops its request on seeing ack is not served twice.
  assign wr_go    = (state == IDLE) && !pending && !eoc_hit && cfg_req_i && !cfg_ack_o;
  assign cnt_last = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign busy_o   = (state != IDLE);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state          <= IDLE;
      pending        <= 1'b0;
      pend_chan      <= '0;
      cnt            <= '0;
      cfg_ack_o      <= 1'b0;
      drp_den_o      <= 1'b0;
      drp_dwe_o      <= 1'b0;
      drp_daddr_o    <= '0;
      drp_di_o       <= '0;
      sample_valid_o <= 1'b0;
      sample_chan_o  <= '0;
      sample_data_o  <= '0;
      overrun_o      <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      drp_den_o      <= 1'b0;
      drp_dwe_o      <= 1'b0;
      sample_valid_o <= 1'b0;
      cfg_ack_o      <= 1'b0;

      if (rd_go) begin
        // Consuming the pending slot: a same-cycle eoc refills it without counting as overrun.
        pending <= pending & eoc_hit;
        if (pending && eoc_hit) pend_chan <= channel_i;
      end else if (eoc_hit) begin
        pending   <= 1'b1;
        pend_chan <= channel_i;
        if (pending) overrun_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rd_go) begin
            drp_den_o   <= 1'b1;
            drp_daddr_o <= {2'b00, rd_chan};
            cnt         <= '0;
            state       <= RD_WAIT;
          end else if (wr_go) begin
            drp_den_o   <= 1'b1;
            drp_dwe_o   <= 1'b1;
            drp_daddr_o <= cfg_addr_i;
            drp_di_o    <= cfg_data_i;
            cnt         <= '0;
            state       <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (drp_drdy_i) begin
            sample_valid_o <= 1'b1;
            sample_chan_o  <= drp_daddr_o[4:0];
            sample_data_o  <= drp_do_i[15:4];
            state          <= IDLE;
          end else if (cnt_last) begin
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WR_WAIT: begin
          // The host gets its ack whether the write landed or was abandoned.
          if (drp_drdy_i || cnt_last) begin
            cfg_ack_o <= 1'b1;
            if (!drp_drdy_i) timeout_o <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
